// File: rtl/stopwatch_lap_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : stopwatch_lap_ctrl                                          |
// | Purpose  : Run/clear sequencer and lap recorder for the stopwatch_csec |
// |            datapath. It turns button edge pulses into run/clear        |
// |            controls, stores lap times in a small buffer and selects    |
// |            the value shown on the 4-digit FND (live time or a lap).    |
// | Ports    : clk, reset_p (async, active high)                           |
// |            btn_pedge[2:0] : [0] start/stop, [1] lap/next, [2] clear    |
// |            cur_value      : live BCD time {sec10,sec1,csec10,csec1}    |
// |            run, clear     : count enable / one-cycle clear pulse       |
// |            disp_value     : BCD value for the FND driver               |
// |            lap_cnt, lap_full, state : lap status and FSM state         |
// | Options  : define STPW_LAP_FREEZE_EN to freeze the display on the      |
// |            captured lap for FREEZE_CYC cycles after a lap in RUN.      |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module stopwatch_lap_ctrl #(
   parameter int LAP_DEPTH  = 4,
   parameter int LAP_AW     = 2,
   parameter int FREEZE_CYC = 100_000_000
) (
   input  logic              clk,
   input  logic              reset_p,
   input  logic [2:0]        btn_pedge,
   input  logic [15:0]       cur_value,
   output logic              run,
   output logic              clear,
   output logic [15:0]       disp_value,
   output logic [LAP_AW:0]   lap_cnt,
   output logic              lap_full,
   output logic [1:0]        state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_VIEW  = 2'd3
   } state_t;

   localparam int              c_cnt_w     = LAP_AW + 1;
   localparam logic [LAP_AW:0] c_lap_depth = c_cnt_w'(LAP_DEPTH);

   state_t              r_state, w_state_nxt;
   logic                r_run;
   logic                r_clear, w_clear_nxt;
   logic [15:0]         r_disp, w_disp_nxt;
   logic [LAP_AW:0]     r_lap_cnt, w_lap_cnt_nxt;
   logic                r_lap_full;
   logic [LAP_AW-1:0]   r_view_ptr, w_view_ptr_nxt;
   logic                w_lap_wr;
   logic [15:0]         r_mem [LAP_DEPTH];

   // Next-state logic. Clear beats start/stop beats lap, but only among the
   // buttons that mean something in the current state (clear is a no-op in
   // RUN, so start/stop still wins there).
   always_comb begin
      w_state_nxt    = r_state;
      w_lap_cnt_nxt  = r_lap_cnt;
      w_view_ptr_nxt = r_view_ptr;
      w_clear_nxt    = 1'b0;
      w_lap_wr       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (btn_pedge[2]) begin
               w_clear_nxt   = 1'b1;
               w_lap_cnt_nxt = '0;
            end else if (btn_pedge[0]) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (btn_pedge[0]) begin
               w_state_nxt = ST_PAUSE;
            end else if (btn_pedge[1] && !r_lap_full) begin
               w_lap_wr      = 1'b1;
               w_lap_cnt_nxt = r_lap_cnt + 1'b1;
            end
         end
         ST_PAUSE, ST_VIEW: begin
            if (btn_pedge[2]) begin
               w_state_nxt   = ST_IDLE;
               w_clear_nxt   = 1'b1;
               w_lap_cnt_nxt = '0;
            end else if (btn_pedge[0]) begin
               // From VIEW start/stop only returns to PAUSE; the time base
               // stays stopped.
               w_state_nxt = (r_state == ST_PAUSE) ? ST_RUN : ST_PAUSE;
            end else if (btn_pedge[1]) begin
               if (r_state == ST_PAUSE) begin
                  if (r_lap_cnt != '0) begin
                     w_state_nxt    = ST_VIEW;
                     w_view_ptr_nxt = '0;
                  end
               end else if ({1'b0, r_view_ptr} == (r_lap_cnt - 1'b1)) begin
                  w_view_ptr_nxt = '0;
               end else begin
                  w_view_ptr_nxt = r_view_ptr + 1'b1;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

`ifdef STPW_LAP_FREEZE_EN
   localparam int                 c_frz_w    = (FREEZE_CYC > 1) ? $clog2(FREEZE_CYC) : 1;
   localparam logic [c_frz_w-1:0] c_frz_load = c_frz_w'(FREEZE_CYC - 1);

   logic [c_frz_w-1:0] r_frz_cnt;
   logic [15:0]        r_frz_val;
   logic               w_frz_act;

   // The display shows the lap on the capture edge anyway (it equals the
   // live value then), so loading FREEZE_CYC-1 yields FREEZE_CYC cycles.
   assign w_frz_act = (r_state == ST_RUN) && (r_frz_cnt != '0);

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         r_frz_cnt <= '0;
         r_frz_val <= '0;
      end else if (w_state_nxt != ST_RUN) begin
         r_frz_cnt <= '0;
      end else if (w_lap_wr) begin
         r_frz_cnt <= c_frz_load;
         r_frz_val <= cur_value;
      end else if (r_frz_cnt != '0) begin
         r_frz_cnt <= r_frz_cnt - 1'b1;
      end
   end

   assign w_disp_nxt = (r_state == ST_VIEW) ? r_mem[r_view_ptr] :
                       w_frz_act            ? r_frz_val         : cur_value;
`else
   localparam int c_unused_frz_cyc = FREEZE_CYC;

   assign w_disp_nxt = (r_state == ST_VIEW) ? r_mem[r_view_ptr] : cur_value;
`endif

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         r_state    <= ST_IDLE;
         r_run      <= 1'b0;
         r_clear    <= 1'b0;
         r_disp     <= '0;
         r_lap_cnt  <= '0;
         r_lap_full <= 1'b0;
         r_view_ptr <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_run      <= (w_state_nxt == ST_RUN);
         r_clear    <= w_clear_nxt;
         r_disp     <= w_disp_nxt;
         r_lap_cnt  <= w_lap_cnt_nxt;
         r_lap_full <= (w_lap_cnt_nxt == c_lap_depth);
         r_view_ptr <= w_view_ptr_nxt;
      end
   end

   // Lap storage has no reset; entries beyond lap_cnt are never read.
   always_ff @(posedge clk) begin
      if (w_lap_wr) begin
         r_mem[r_lap_cnt[LAP_AW-1:0]] <= cur_value;
      end
   end

   assign run        = r_run;
   assign clear      = r_clear;
   assign disp_value = r_disp;
   assign lap_cnt    = r_lap_cnt;
   assign lap_full   = r_lap_full;
   assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_lap_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_stopwatch_lap_ctrl                                       |
// | Purpose  : Self-checking bench for stopwatch_lap_ctrl with a           |
// |            behavioural lap-list model and randomized button traffic.   |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_stopwatch_lap_ctrl;

   localparam int LAP_DEPTH  = 4;
   localparam int LAP_AW     = 2;
   localparam int FREEZE_CYC = 10;
`ifdef STPW_LAP_FREEZE_EN
   localparam bit c_frz_en = 1'b1;
`else
   localparam bit c_frz_en = 1'b0;
`endif
   localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_VIEW = 2'd3;

   logic              clk;
   logic              reset_p;
   logic [2:0]        btn_pedge;
   logic [15:0]       cur_value;
   logic              run, clear, lap_full;
   logic [15:0]       disp_value;
   logic [LAP_AW:0]   lap_cnt;
   logic [1:0]        state;

   stopwatch_lap_ctrl #(
      .LAP_DEPTH  (LAP_DEPTH),
      .LAP_AW     (LAP_AW),
      .FREEZE_CYC (FREEZE_CYC)
   ) u_dut (
      .clk        (clk),
      .reset_p    (reset_p),
      .btn_pedge  (btn_pedge),
      .cur_value  (cur_value),
      .run        (run),
      .clear      (clear),
      .disp_value (disp_value),
      .lap_cnt    (lap_cnt),
      .lap_full   (lap_full),
      .state      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: laps are a list, the freeze is a "frozen until cycle N".
   logic [1:0]      m_st;
   logic [15:0]     m_laps[$];
   int              m_ptr;
   logic            m_run, m_clear, m_full;
   logic [15:0]     m_disp;
   logic [LAP_AW:0] m_cnt;
   logic [15:0]     m_frz_val;
   longint          m_frz_until;
   longint          cyc = 0;

   wire  [23:0] dut_vec = {run, clear, disp_value, lap_cnt, lap_full, state};
   wire  [23:0] m_vec   = {m_run, m_clear, m_disp, m_cnt, m_full, m_st};

   task automatic model_reset();
      m_st = S_IDLE; m_laps.delete(); m_ptr = 0;
      m_run = 1'b0; m_clear = 1'b0; m_disp = 16'h0000;
      m_cnt = '0; m_full = 1'b0; m_frz_val = 16'h0000; m_frz_until = 0;
   endtask

   // One clock edge of the specified behaviour; the display reflects the
   // situation just before the edge.
   task automatic model_edge(input logic [2:0] b, input logic [15:0] v);
      logic [15:0] nd;
      cyc++;
      if (m_st == S_VIEW)                           nd = m_laps[m_ptr];
      else if (m_st == S_RUN && cyc <= m_frz_until) nd = m_frz_val;
      else                                          nd = v;
      m_clear = 1'b0;
      case (m_st)
         S_IDLE:
            if (b[2]) m_clear = 1'b1;
            else if (b[0]) m_st = S_RUN;
         S_RUN:
            if (b[0]) m_st = S_PAUSE;
            else if (b[1] && m_laps.size() < LAP_DEPTH) begin
               m_laps.push_back(v);
               if (c_frz_en) begin
                  m_frz_val   = v;
                  m_frz_until = cyc + FREEZE_CYC - 1;
               end
            end
         default: begin
            if (b[2]) begin
               m_st = S_IDLE; m_clear = 1'b1; m_laps.delete();
            end else if (b[0]) begin
               m_st = (m_st == S_PAUSE) ? S_RUN : S_PAUSE;
            end else if (b[1]) begin
               if (m_st == S_VIEW) m_ptr = (m_ptr + 1) % m_laps.size();
               else if (m_laps.size() > 0) begin
                  m_st = S_VIEW; m_ptr = 0;
               end
            end
         end
      endcase
      if (m_st != S_RUN) m_frz_until = 0;
      m_disp = nd;
      m_run  = (m_st == S_RUN);
      m_cnt  = (LAP_AW + 1)'(m_laps.size());
      m_full = (m_laps.size() == LAP_DEPTH);
   endtask

   task automatic step(input logic [2:0] b, input logic [15:0] v);
      @(negedge clk);
      btn_pedge = b;
      cur_value = v;
      @(posedge clk);
      model_edge(b, v);
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      btn_pedge = 3'b000;
      #2 reset_p = 1'b1;
      #1;
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset_p = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      n_vec++;
      if (dut_vec !== 24'h0) begin
         n_err++; $display("FAIL reset_outputs: got %h expected %h", dut_vec, 24'h0);
      end
      model_reset();
      release_reset();
      step(3'b000, 16'h0042);
      n_vec++;
      if (dut_vec !== m_vec || disp_value !== 16'h0042) begin
         n_err++; $display("FAIL reset_idle_live: got %h expected %h", dut_vec, m_vec);
      end
   endtask

   task automatic test_start_stop();
      step(3'b001, 16'h0000);
      n_vec++;
      if (run !== 1'b1 || state !== S_RUN) begin
         n_err++; $display("FAIL start_run: run=%b state=%0d expected run=1 state=1", run, state);
      end
      step(3'b001, 16'h0007);
      n_vec++;
      if (run !== 1'b0 || state !== S_PAUSE || dut_vec !== m_vec) begin
         n_err++; $display("FAIL stop_pause: got %h expected %h", dut_vec, m_vec);
      end
   endtask

   task automatic test_laps();
      logic [15:0] lv[5];
      logic [15:0] vw[4];
      lv = '{16'h0123, 16'h0245, 16'h0310, 16'h0402, 16'h0511};
      vw = '{16'h0245, 16'h0310, 16'h0402, 16'h0123};
      step(3'b001, 16'h0100);
      for (int i = 0; i < 5; i++) begin
         step(3'b010, lv[i]);
         n_vec++;
         if (lap_cnt !== 3'((i < 4) ? i + 1 : 4) || dut_vec !== m_vec) begin
            n_err++; $display("FAIL lap_capture_%0d: got %h expected %h", i, dut_vec, m_vec);
         end
         step(3'b000, 16'(16'h0600 + i));
      end
      n_vec++;
      if (lap_cnt !== 3'd4 || lap_full !== 1'b1) begin
         n_err++; $display("FAIL lap_full: cnt=%0d full=%b expected cnt=4 full=1", lap_cnt, lap_full);
      end
      step(3'b001, 16'h0700);
      step(3'b010, 16'h0701);
      step(3'b000, 16'h0702);
      n_vec++;
      if (state !== S_VIEW || disp_value !== 16'h0123) begin
         n_err++; $display("FAIL view_first: state=%0d disp=%h expected state=3 disp=0123", state, disp_value);
      end
      for (int i = 0; i < 4; i++) begin
         step(3'b010, 16'h0800);
         step(3'b000, 16'h0801);
         n_vec++;
         if (disp_value !== vw[i] || dut_vec !== m_vec) begin
            n_err++; $display("FAIL view_next_%0d: disp=%h expected %h", i, disp_value, vw[i]);
         end
      end
   endtask

   task automatic test_clear_from_view();
      step(3'b100, 16'h0900);
      n_vec++;
      if (clear !== 1'b1 || state !== S_IDLE || lap_cnt !== 3'd0 || lap_full !== 1'b0) begin
         n_err++; $display("FAIL view_clear: got %h expected clear=1 state=0 cnt=0", dut_vec);
      end
      step(3'b000, 16'h0901);
      n_vec++;
      if (clear !== 1'b0 || dut_vec !== m_vec) begin
         n_err++; $display("FAIL clear_single: got %h expected %h", dut_vec, m_vec);
      end
      step(3'b001, 16'h0000);
      step(3'b001, 16'h0003);
      step(3'b010, 16'h0003);
      n_vec++;
      if (state !== S_PAUSE || dut_vec !== m_vec) begin
         n_err++; $display("FAIL empty_view_ignored: state=%0d expected 2", state);
      end
   endtask

   task automatic test_simultaneous();
      step(3'b001, 16'h0010);
      step(3'b111, 16'h0011);
      n_vec++;
      if (state !== S_PAUSE || lap_cnt !== 3'd0 || clear !== 1'b0 || run !== 1'b0) begin
         n_err++; $display("FAIL btn_111_run: got %h expected state=2 cnt=0 clear=0", dut_vec);
      end
      step(3'b011, 16'h0012);
      n_vec++;
      if (state !== S_RUN || run !== 1'b1 || lap_cnt !== 3'd0 || dut_vec !== m_vec) begin
         n_err++; $display("FAIL btn_011_pause: got %h expected %h", dut_vec, m_vec);
      end
   endtask

   task automatic test_random();
      logic [2:0] b;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            apply_reset();
            model_reset();
            n_vec++;
            if (dut_vec !== 24'h0) begin
               n_err++; $display("FAIL rand_reset_%0d: got %h expected 0", i, dut_vec);
            end
            release_reset();
         end
         b[0] = ($urandom_range(0, 6) == 0);
         b[1] = ($urandom_range(0, 3) == 0);
         b[2] = ($urandom_range(0, 24) == 0);
         step(b, 16'($urandom));
         n_vec++;
         if (dut_vec !== m_vec) begin
            n_err++; $display("FAIL rand_%0d btn=%b: got %h expected %h", i, b, dut_vec, m_vec);
         end
      end
   endtask

`ifdef STPW_LAP_FREEZE_EN
   task automatic test_freeze();
      apply_reset();
      model_reset();
      release_reset();
      step(3'b001, 16'h0148);
      step(3'b010, 16'h0150);
      n_vec++;
      if (disp_value !== 16'h0150) begin
         n_err++; $display("FAIL freeze_capture: disp=%h expected 0150", disp_value);
      end
      for (int k = 1; k <= 10; k++) begin
         step(3'b000, 16'(16'h0200 + k));
         n_vec++;
         if (disp_value !== ((k <= 9) ? 16'h0150 : 16'(16'h0200 + k)) || dut_vec !== m_vec) begin
            n_err++; $display("FAIL freeze_hold_%0d: got %h expected %h", k, dut_vec, m_vec);
         end
      end
      step(3'b010, 16'h0777);
      step(3'b000, 16'h0778);
      step(3'b000, 16'h0779);
      n_vec++;
      if (disp_value !== 16'h0777 || run !== 1'b1) begin
         n_err++; $display("FAIL freeze_second: disp=%h run=%b expected 0777 1", disp_value, run);
      end
      apply_reset();
      n_vec++;
      if (disp_value !== 16'h0000 || dut_vec !== 24'h0) begin
         n_err++; $display("FAIL freeze_reset: got %h expected 0", dut_vec);
      end
      model_reset();
      release_reset();
   endtask
`endif

   initial begin
      reset_p   = 1'b1;
      btn_pedge = 3'b000;
      cur_value = 16'h0000;
      model_reset();
      test_reset();
      test_start_stop();
      test_laps();
      test_clear_from_view();
      test_simultaneous();
`ifdef STPW_LAP_FREEZE_EN
      test_freeze();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/stopwatch_lap_ctrl.md
# stopwatch_lap_ctrl

Control sequencer for the `stopwatch_csec` datapath: turns the three debounced button edge pulses into run/clear controls and records lap times. Lap times go into a small on-chip buffer, and the block selects what the 4-digit FND shows: the live time or a stored lap. It sits between the button edge detectors and the `stopwatch_csec` time base / FND driver.

## Interface
Parameters:
- `LAP_DEPTH`, 4: number of lap entries; power of two, 2..16
- `LAP_AW`, 2: log2(`LAP_DEPTH`)
- `FREEZE_CYC`, 100_000_000: display-freeze duration in clk cycles (1 s at 100 MHz); used only with `STPW_LAP_FREEZE_EN`

Ports:
- `clk`  in  1  system clock, 100 MHz
- `reset_p`  in  1  asynchronous, active-high reset
- `btn_pedge`  in  3  single-cycle edge pulses:
  - [0] start/stop
  - [1] lap/next
  - [2] clear
- `cur_value`  in  16  live BCD time from datapath, {sec10, sec1, csec10, csec1}
- `run`  out  1  count enable to time base
- `clear`  out  1  one-cycle clear pulse to datapath
- `disp_value`  out  16  BCD value for FND driver
- `lap_cnt`  out  `LAP_AW`+1  number of stored laps, 0..`LAP_DEPTH`
- `lap_full`  out  1  `lap_cnt` == `LAP_DEPTH`
- `state`  out  2  FSM state: IDLE=0, RUN=1, PAUSE=2, VIEW=3

## Operation
- Button priority when several bits are set in one cycle: [2] > [0] > [1]. Lower-priority bits are dropped.
- IDLE:
  - [0] -> RUN.
  - [2] -> `clear` pulse; stay in IDLE.
  - [1] ignored.
- RUN:
  - [0] -> PAUSE.
  - [1]: if not full, write `cur_value` to mem[`lap_cnt`] and increment `lap_cnt`. If full, ignore; no overwrite.
  - [2] ignored.
- PAUSE:
  - [0] -> RUN.
  - [1] -> VIEW with `view_ptr`=0, only if `lap_cnt`>0; otherwise ignored.
  - [2] -> IDLE, `clear` pulse, `lap_cnt`=0.
- VIEW:
  - [1] -> `view_ptr`+1; wraps to 0 after `lap_cnt`-1.
  - [0] -> PAUSE (the datapath does not restart).
  - [2] -> as in PAUSE.
- `run` = 1 only in RUN.
- `disp_value` source:
  - VIEW: mem[`view_ptr`]
  - RUN with an active freeze: the frozen value
  - all other cases: `cur_value`
- Lap entries are stored verbatim. No BCD arithmetic; no split times.

## Timing
- All outputs are registered.
- `run` and `state` change on the clk edge after the cycle in which `btn_pedge` is sampled high.
- `clear` is high for exactly one cycle, the cycle after the [2] sample. It is never asserted in RUN.
- Lap capture takes `cur_value` as sampled on the same edge as [1]. `lap_cnt` and `lap_full` update on that edge.
- `disp_value` has one-cycle latency from `cur_value` or from the memory read.
- On reset, asynchronously:
  - `state`=IDLE
  - `run`=0, `clear`=0
  - `disp_value`=16'h0000
  - `lap_cnt`=0, `lap_full`=0
  - `view_ptr`=0, freeze counter=0
  - mem contents don't-care
- Reset mid-RUN or mid-VIEW drops all state immediately, with no clear pulse.
- Sustained `btn_pedge` high is treated as one event per cycle. The block does not debounce.

## Configuration
- `STPW_LAP_FREEZE_EN` defined:
  - A successful lap capture in RUN loads the freeze counter with `FREEZE_CYC`-1. `disp_value` shows the captured lap until the counter reaches 0, then returns to live.
  - A new capture during a freeze reloads both the counter and the frozen value.
  - Leaving RUN cancels the freeze.
  - A lap press while full does not start a freeze.
  - `run` is unaffected throughout.
- Not defined: no freeze counter is built, `FREEZE_CYC` is unused, and `disp_value` in RUN always shows `cur_value`.

## Test plan
- Reset, then check all outputs are 0 and `state`=0.
- Pulse [0], check `run`=1 one cycle later. Pulse [0] again, check `state`=2 and `run`=0.
- RUN with `cur_value` = 16'h0123, 16'h0245, 16'h0310, 16'h0402, 16'h0511, one lap pulse each. Check:
  - `lap_cnt` = 4 and `lap_full` = 1
  - the 5th press is dropped
  - PAUSE, then [1] enters VIEW showing 16'h0123
  - four more [1] pulses show 16'h0245, 16'h0310, 16'h0402, then wrap to 16'h0123
- In VIEW, pulse [2]. Check a single `clear` pulse, `state`=0 and `lap_cnt`=0. In PAUSE with `lap_cnt`=0, check [1] keeps `state`=2.
- Simultaneous `btn_pedge`=3'b111 in RUN: check transition to PAUSE, no capture, no clear. Then `btn_pedge`=3'b011 in PAUSE: check RUN.
- With `STPW_LAP_FREEZE_EN` and `FREEZE_CYC`=10, lap at 16'h0150:
  - `disp_value` holds 16'h0150 for 10 cycles while `cur_value` advances, then tracks live
  - assert `reset_p` mid-freeze: `disp_value`=0 at once
